pixel_bus_sink: RTL and testbench

//  Receiving end of the shared pixel write bus (draw_enable/x/y/RGB) driven by the tile drawers.

---
 rtl/pixel_bus_sink.sv | 154 +++++++++++++++
 tb/tb_pixel_bus_sink.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_bus_sink.sv
// Receiving end of the shared pixel write bus: buffers on-screen writes, reduces colour depth,
// and forwards them (or a full-screen clear sweep) to the framebuffer over valid/ready.
module pixel_bus_sink #(
  parameter int FIFO_DEPTH  = 8,
  parameter int COLOUR_BITS = 3,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               bus_draw_enable,
  input  logic [7:0]                         bus_x,
  input  logic [7:0]                         bus_y,
  input  logic [23:0]                        bus_rgb,
  input  logic                               clear,
  input  logic [23:0]                        clear_rgb,
  input  logic                               fb_ready,
  output logic                               fb_plot,
  output logic [7:0]                         fb_x,
  output logic [7:0]                         fb_y,
  output logic [3*COLOUR_BITS-1:0]           fb_colour,
  output logic                               busy,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int CW = 3*COLOUR_BITS;
  localparam int EW = 16 + CW;
  localparam logic [7:0] X_LAST = 8'(SCREEN_W-1);
  localparam logic [7:0] Y_LAST = 8'(SCREEN_H-1);

  typedef enum logic [1:0] {S_PASS, S_CLEAR_WAIT, S_CLEAR} state_t;

  function automatic logic [CW-1:0] reduce_rgb(input logic [23:0] rgb);
    return {rgb[23 -: COLOUR_BITS], rgb[15 -: COLOUR_BITS], rgb[7 -: COLOUR_BITS]};
  endfunction

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count, drain_cnt;
  logic          full, empty, on_screen, push, pop;
  logic          load_ok, src_valid, from_sweep, clear_accept;
  logic [EW-1:0] src_data;
  logic [CW-1:0] clear_colour;
  logic [7:0]    sweep_x, sweep_y;
  logic          sweep_done;
  state_t        state, state_next;

  assign full      = (count == LW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign on_screen = (int'(bus_x) < SCREEN_W) && (int'(bus_y) < SCREEN_H);
  assign load_ok   = !fb_plot || fb_ready;
  // A full FIFO still takes a write when the head leaves in the same edge.
  assign push      = bus_draw_enable && on_screen && (!full || pop);

  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    src_valid    = 1'b0;
    from_sweep   = 1'b0;
    clear_accept = 1'b0;
    src_data     = mem[rd_ptr];
    case (state)
      S_PASS: begin
        src_valid = !empty;
        pop       = !empty && load_ok;
        if (clear) begin
          clear_accept = 1'b1;
          state_next   = S_CLEAR_WAIT;
        end
      end
      S_CLEAR_WAIT: begin
        // Only the entries that were queued before the request may leave ahead of the sweep.
        if (drain_cnt != '0) begin
          src_valid = 1'b1;
          pop       = load_ok;
        end else if (load_ok) begin
          state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!sweep_done) begin
          src_valid  = 1'b1;
          from_sweep = 1'b1;
          src_data   = {sweep_x, sweep_y, clear_colour};
        end else if (load_ok) begin
          state_next = S_PASS;
        end
      end
      default: state_next = S_PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus_x, bus_y, reduce_rgb(bus_rgb)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_PASS;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      fb_plot      <= 1'b0;
      fb_x         <= '0;
      fb_y         <= '0;
      fb_colour    <= '0;
      drain_cnt    <= '0;
      clear_colour <= '0;
      sweep_x      <= '0;
      sweep_y      <= '0;
      sweep_done   <= 1'b0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + LW'(push) - LW'(pop);
      if (bus_draw_enable && on_screen && full && !pop) overflow <= 1'b1;

      // Output stage: reloads in the same edge it hands a beat over.
      if (load_ok) begin
        fb_plot <= src_valid;
        if (src_valid) {fb_x, fb_y, fb_colour} <= src_data;
      end

      if (clear_accept) begin
        clear_colour <= reduce_rgb(clear_rgb);
        drain_cnt    <= count - LW'(pop);
        sweep_x      <= '0;
        sweep_y      <= '0;
        sweep_done   <= 1'b0;
      end else if (state == S_CLEAR_WAIT && pop) begin
        drain_cnt <= drain_cnt - LW'(1);
      end

      if (from_sweep && load_ok) begin
        if (sweep_x == X_LAST) begin
          sweep_x <= '0;
          if (sweep_y == Y_LAST) sweep_done <= 1'b1;
          else                   sweep_y    <= sweep_y + 8'd1;
        end else begin
          sweep_x <= sweep_x + 8'd1;
        end
      end
    end
  end

  assign busy       = (state != S_PASS);
  assign fifo_level = count;

endmodule

// File: tb/tb_pixel_bus_sink.sv
// Scoreboard bench for pixel_bus_sink: expected beats are queued as stimulus is driven and
// compared, in order, at every fb_plot/fb_ready transfer.
module tb_pixel_bus_sink;

  logic        clk = 1'b0;
  logic        reset, bus_draw_enable, clear, fb_ready;
  logic [7:0]  bus_x, bus_y;
  logic [23:0] bus_rgb, clear_rgb;
  logic        fb_plot, busy, overflow;
  logic [7:0]  fb_x, fb_y;
  logic [8:0]  fb_colour;
  logic [3:0]  fifo_level;

  int checks = 0;
  int fails  = 0;
  int beats  = 0;
  logic [24:0] sb [$];

  logic        hold_pending = 1'b0;
  logic [24:0] held;

  pixel_bus_sink #(.FIFO_DEPTH(8), .COLOUR_BITS(3), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .reset(reset), .bus_draw_enable(bus_draw_enable), .bus_x(bus_x), .bus_y(bus_y),
    .bus_rgb(bus_rgb), .clear(clear), .clear_rgb(clear_rgb), .fb_ready(fb_ready),
    .fb_plot(fb_plot), .fb_x(fb_x), .fb_y(fb_y), .fb_colour(fb_colour), .busy(busy),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] red(input logic [23:0] c);
    return {c[23:21], c[15:13], c[7:5]};
  endfunction

  // Transfer monitor: inputs change just after posedge, so the negedge sees what the next edge sees.
  always @(negedge clk) begin
    logic [24:0] got, exp_v;
    got = {fb_x, fb_y, fb_colour};
    if (hold_pending) begin
      checks++;
      if (fb_plot !== 1'b1 || got !== held) begin
        fails++;
        $display("FAIL stall_hold: got plot=%b %h, required plot=1 %h", fb_plot, got, held);
      end
    end
    hold_pending = !reset && fb_plot === 1'b1 && fb_ready === 1'b0;
    held = got;
    if (!reset && fb_plot === 1'b1 && fb_ready === 1'b1) begin
      beats++;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: got x=%0d y=%0d c=%b, required no beat", fb_x, fb_y, fb_colour);
      end else begin
        exp_v = sb.pop_front();
        if (got !== exp_v) begin
          fails++;
          $display("FAIL beat_%0d: got x=%0d y=%0d c=%b, required x=%0d y=%0d c=%b", beats,
                   fb_x, fb_y, fb_colour, exp_v[24:17], exp_v[16:9], exp_v[8:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [7:0] x, input logic [7:0] y, input logic [23:0] rgb,
                          input bit expect_out);
    bus_x = x; bus_y = y; bus_rgb = rgb; bus_draw_enable = 1'b1;
    if (expect_out) sb.push_back({x, y, red(rgb)});
    tick();
    bus_draw_enable = 1'b0;
  endtask

  task automatic push_sweep(input logic [8:0] col);
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        sb.push_back({8'(xx), 8'(yy), col});
  endtask

  task automatic wait_drain(input int budget, input bit rand_ready, input string name);
    int n = 0;
    while (n < budget && !(sb.size() == 0 && fb_plot === 1'b0 && fifo_level === 4'd0 && busy === 1'b0)) begin
      if (rand_ready) fb_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    fb_ready = 1'b1;
    checks++;
    if (n >= budget) begin
      fails++;
      $display("FAIL %s_drain: still queue=%0d plot=%b level=%0d busy=%b after %0d cycles, required all idle",
               name, sb.size(), fb_plot, fifo_level, busy, n);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus_draw_enable = 1'b0; bus_x = '0; bus_y = '0; bus_rgb = '0;
    clear = 1'b0; clear_rgb = '0; fb_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({fb_plot, fb_x, fb_y, fb_colour, busy, overflow, fifo_level} !== '0) begin
      fails++;
      $display("FAIL reset_state: got plot=%b x=%0d y=%0d c=%b busy=%b ovf=%b lvl=%0d, required all 0",
               fb_plot, fb_x, fb_y, fb_colour, busy, overflow, fifo_level);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    fb_ready = 1'b1;
    write_px(8'd5, 8'd7, 24'hFF8000, 1'b1);
    checks++;
    if (fb_plot !== 1'b0 || fifo_level !== 4'd1) begin
      fails++;
      $display("FAIL single_k: got plot=%b lvl=%0d, required plot=0 lvl=1", fb_plot, fifo_level);
    end
    tick();
    checks++;
    if (fb_plot !== 1'b1 || fb_x !== 8'd5 || fb_y !== 8'd7 || fb_colour !== 9'b111_100_000) begin
      fails++;
      $display("FAIL single_k1: got plot=%b x=%0d y=%0d c=%b, required plot=1 x=5 y=7 c=111100000",
               fb_plot, fb_x, fb_y, fb_colour);
    end
    tick();
    checks++;
    if (fb_plot !== 1'b0 || fifo_level !== 4'd0) begin
      fails++;
      $display("FAIL single_k2: got plot=%b lvl=%0d, required plot=0 lvl=0", fb_plot, fifo_level);
    end
  endtask

  task automatic test_overflow();
    fb_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      write_px(8'(10 + i), 8'(20 + i), $urandom(), i < 9);
    checks++;
    if (fifo_level !== 4'd8 || overflow !== 1'b1 || fb_plot !== 1'b1) begin
      fails++;
      $display("FAIL overflow_full: got lvl=%0d ovf=%b plot=%b, required lvl=8 ovf=1 plot=1",
               fifo_level, overflow, fb_plot);
    end
    // Push into the full FIFO on the same edge the head leaves: must be kept.
    fb_ready = 1'b1;
    write_px(8'd99, 8'd98, 24'h00FF00, 1'b1);
    checks++;
    if (fifo_level !== 4'd8) begin
      fails++;
      $display("FAIL full_push_pop: got lvl=%0d, required 8", fifo_level);
    end
    wait_drain(100, 1'b0, "overflow");
    apply_reset();
    checks++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow_cleared: got %b, required 0", overflow);
    end
  endtask

  task automatic test_offscreen();
    fb_ready = 1'b1;
    write_px(8'd160, 8'd0, 24'hFFFFFF, 1'b0);
    write_px(8'd0, 8'd120, 24'hFFFFFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fb_plot !== 1'b0 || overflow !== 1'b0 || fifo_level !== 4'd0) begin
        fails++;
        $display("FAIL offscreen: got plot=%b ovf=%b lvl=%0d, required 0 0 0", fb_plot, overflow, fifo_level);
      end
      tick();
    end
    write_px(8'd159, 8'd119, 24'h20A0E0, 1'b1);
    wait_drain(20, 1'b0, "edge_pixel");
  endtask

  task automatic test_clear_sweep();
    int b0;
    fb_ready = 1'b1;
    b0 = beats;
    clear_rgb = 24'h0000FF; clear = 1'b1;
    push_sweep(9'b000_000_111);
    tick();
    clear = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL clear_busy: got %b, required 1", busy);
    end
    for (int i = 0; i < 50; i++) tick();
    clear_rgb = 24'hFFFFFF; clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_drain(25000, 1'b0, "sweep");
    checks++;
    if (beats - b0 !== 19200) begin
      fails++;
      $display("FAIL sweep_count: got %0d beats, required 19200", beats - b0);
    end
    b0 = beats;
    clear_rgb = 24'h0000FF; clear = 1'b1;
    push_sweep(9'b000_000_111);
    tick();
    clear = 1'b0;
    wait_drain(45000, 1'b1, "sweep_random");
    checks++;
    if (beats - b0 !== 19200) begin
      fails++;
      $display("FAIL sweep_random_count: got %0d beats, required 19200", beats - b0);
    end
  endtask

  task automatic test_clear_ordering();
    fb_ready = 1'b0;
    write_px(8'd1, 8'd2, 24'hFF0000, 1'b1);
    write_px(8'd3, 8'd4, 24'h00FF00, 1'b1);
    write_px(8'd5, 8'd6, 24'h0000FF, 1'b1);
    clear_rgb = 24'h123456; clear = 1'b1;
    push_sweep(9'b000_001_010);
    tick();
    clear = 1'b0;
    fb_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    write_px(8'd150, 8'd110, 24'hC0C0C0, 1'b1);
    write_px(8'd0, 8'd0, 24'h808080, 1'b1);
    wait_drain(25000, 1'b0, "clear_order");
  endtask

  task automatic test_reset_mid();
    int b0;
    fb_ready = 1'b1;
    clear_rgb = 24'h000000; clear = 1'b1;
    push_sweep(9'b000_000_000);
    tick();
    clear = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    fb_ready = 1'b0;
    for (int i = 0; i < 10; i++) write_px(8'(i), 8'd50, 24'hABCDEF, 1'b0);
    checks++;
    if (overflow !== 1'b1 || fifo_level !== 4'd8 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: got ovf=%b lvl=%0d busy=%b, required 1 8 1", overflow, fifo_level, busy);
    end
    sb.delete();
    reset = 1'b1;
    tick();
    checks++;
    if (fb_plot !== 1'b0 || busy !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got plot=%b busy=%b lvl=%0d ovf=%b, required 0 0 0 0",
               fb_plot, busy, fifo_level, overflow);
    end
    reset = 1'b0;
    fb_ready = 1'b1;
    b0 = beats;
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (beats !== b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL after_reset: got %0d beats busy=%b, required 0 beats busy=0", beats - b0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_offscreen();
    test_clear_sweep();
    test_clear_ordering();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
